// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry first-word-fall-through FIFO between fetch and decode.
// Shows a NOP bubble while empty; flush drops all entries on the next edge.
module if_id_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] NOP_INST = 'h00000013
)(
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [ADDR_W-1:0]            pc_addr_if,
  input  logic [INST_W-1:0]            fetched_inst_if,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [ADDR_W-1:0]            pc_addr_id,
  output logic [INST_W-1:0]            fetched_inst_id,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop;
  entry_t             head;

  // Ready depends only on registered occupancy, so a full queue refuses a push
  // even when decode pops in the same cycle.
  assign if_ready = (count != CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  assign head            = mem[rd_ptr];
  assign pc_addr_id      = id_valid ? head.pc   : '0;
  assign fetched_inst_id = id_valid ? head.inst : NOP_INST;

  // Storage is not reset; id_valid masks stale contents.
  always_ff @(posedge sys_clk) begin
    if (push && !flush) mem[wr_ptr] <= '{pc: pc_addr_if, inst: fetched_inst_if};
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, streaming, fill/drain, wrap, flush, async reset.
module tb_if_id_queue;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              sys_clk, rst, flush, if_valid, if_ready, id_valid, id_ready;
  logic [ADDR_W-1:0] pc_addr_if, pc_addr_id;
  logic [INST_W-1:0] fetched_inst_if, fetched_inst_id;
  logic [2:0]        count;

  int errors = 0;
  int checks = 0;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .sys_clk(sys_clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .pc_addr_if(pc_addr_if), .fetched_inst_if(fetched_inst_if),
    .id_valid(id_valid), .id_ready(id_ready),
    .pc_addr_id(pc_addr_id), .fetched_inst_id(fetched_inst_id),
    .count(count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [2:0] cnt);
    chk({tag, ".valid"}, 64'(id_valid), 64'(1));
    chk({tag, ".pc"},    64'(pc_addr_id), 64'(pc));
    chk({tag, ".inst"},  64'(fetched_inst_id), 64'(inst));
    chk({tag, ".count"}, 64'(count), 64'(cnt));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(id_valid), 64'(0));
    chk({tag, ".pc"},    64'(pc_addr_id), 64'(0));
    chk({tag, ".inst"},  64'(fetched_inst_id), 64'(NOP));
    chk({tag, ".count"}, 64'(count), 64'(0));
  endtask

  initial begin
    int n_push, n_pop;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    pc_addr_if = '0; fetched_inst_if = '0;

    // Reset
    repeat (5) tick();
    chk_empty("in_reset");
    rst = 1'b0;
    tick();
    chk_empty("post_reset");
    chk("post_reset.if_ready", 64'(if_ready), 64'(1));

    // Streaming with decode always ready
    id_ready = 1'b1; if_valid = 1'b1;
    pc_addr_if = 32'h0; fetched_inst_if = 32'h00100093;
    chk("stream0.same_cycle_no_pop", 64'(id_valid), 64'(0));
    tick();
    chk_head("stream0", 32'h0, 32'h00100093, 3'd1);
    pc_addr_if = 32'h4; fetched_inst_if = 32'h00200113;
    tick();
    chk_head("stream1", 32'h4, 32'h00200113, 3'd1);
    pc_addr_if = 32'h8; fetched_inst_if = 32'h00300193;
    tick();
    chk_head("stream2", 32'h8, 32'h00300193, 3'd1);
    if_valid = 1'b0;
    tick();
    chk_empty("stream_end");

    // Stall to full
    id_ready = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_addr_if = 32'(i * 4); fetched_inst_if = 32'h1000 + 32'(i);
      chk($sformatf("fill%0d.if_ready", i), 64'(if_ready), 64'(i < 4));
      if (i < 4) tick();
    end
    chk_head("full", 32'h0, 32'h1000, 3'd4);
    tick();  // still stalled with pc 0x10 offered
    chk_head("full_hold", 32'h0, 32'h1000, 3'd4);
    chk("full_hold.if_ready", 64'(if_ready), 64'(0));
    id_ready = 1'b1;
    tick();
    chk_head("drain0", 32'h4, 32'h1001, 3'd3);
    chk("drain0.if_ready", 64'(if_ready), 64'(1));
    tick();  // 0x10 accepted now, 0x4 popped
    chk_head("drain1", 32'h8, 32'h1002, 3'd3);
    if_valid = 1'b0;
    tick();
    chk_head("drain2", 32'hC, 32'h1003, 3'd2);
    tick();
    chk_head("drain3", 32'h10, 32'h1004, 3'd1);
    tick();
    chk_empty("drained");

    // Wrap-around: 10 entries, decode ready on alternate cycles
    n_push = 0; n_pop = 0;
    for (int cyc = 0; cyc < 60 && n_pop < 10; cyc++) begin
      logic do_push, do_pop;
      if_valid = (n_push < 10);
      pc_addr_if = 32'h100 + 32'(n_push * 4);
      fetched_inst_if = 32'hA000 + 32'(n_push);
      id_ready = cyc[0];
      #1;
      do_push = if_valid & if_ready;
      do_pop  = id_valid & id_ready;
      if (do_pop) begin
        chk($sformatf("wrap%0d.pc", n_pop), 64'(pc_addr_id), 64'(32'h100 + 32'(n_pop * 4)));
        chk($sformatf("wrap%0d.inst", n_pop), 64'(fetched_inst_id), 64'(32'hA000 + 32'(n_pop)));
      end
      chk($sformatf("wrap_c%0d.occupancy", cyc), 64'(count), 64'(n_push - n_pop));
      tick();
      if (do_push) n_push++;
      if (do_pop)  n_pop++;
    end
    if_valid = 1'b0; id_ready = 1'b0;
    chk("wrap.pops", 64'(n_pop), 64'(10));
    chk_empty("wrap_end");

    // Flush
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_addr_if = 32'h200 + 32'(i * 4); fetched_inst_if = 32'hC000 + 32'(i);
      tick();
    end
    chk_head("pre_flush", 32'h200, 32'hC000, 3'd3);
    flush = 1'b1; pc_addr_if = 32'h40; fetched_inst_if = 32'hDEAD; id_ready = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    chk_empty("post_flush");
    if_valid = 1'b1; pc_addr_if = 32'h80; fetched_inst_if = 32'hBEEF;
    tick();
    chk_head("after_flush", 32'h80, 32'hBEEF, 3'd1);

    // Async reset mid-stream
    pc_addr_if = 32'h84; fetched_inst_if = 32'hBEF0;
    tick();
    if_valid = 1'b0;
    chk_head("pre_areset", 32'h80, 32'hBEEF, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk_empty("areset");
    rst = 1'b0;
    tick();
    chk("after_areset.if_ready", 64'(if_ready), 64'(1));
    chk_empty("after_areset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- DEPTH-entry first-word-fall-through queue between instruction fetch (pc + instruction-memory controller) and decode.
- Adds valid/ready handshake on both sides, decode back-pressure (stall), synchronous flush for branch redirect, and NOP bubble insertion when empty.
- Lets fetch run ahead of a stalled decode without losing or duplicating instructions.

Parameters:
- ADDR_W, 32, width of pc_addr_if / pc_addr_id.
- INST_W, 32, width of the instruction word.
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, word presented on fetched_inst_id when empty (addi x0,x0,0); width INST_W.

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries (branch/jump redirect).
- if_valid  in  1  fetch side presents a valid pc/instruction pair.
- if_ready  out  1  queue can accept a push this cycle.
- pc_addr_if  in  ADDR_W  pc of the fetched instruction.
- fetched_inst_if  in  INST_W  fetched instruction.
- id_valid  out  1  head entry is valid for decode.
- id_ready  in  1  decode consumes head this cycle; 0 = stall.
- pc_addr_id  out  ADDR_W  pc of head entry.
- fetched_inst_id  out  INST_W  instruction of head entry.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
Reset (rst=1, asynchronous):
- count=0, read/write pointers=0, id_valid=0, pc_addr_id=0, fetched_inst_id=NOP_INST, if_ready=1 (once rst deasserts).
- Storage contents need not be cleared.
- Reset asserted mid-operation discards all entries immediately, independent of sys_clk.

Handshake:
- push = if_valid & if_ready.
- pop = id_valid & id_ready.
- if_ready = (count != DEPTH). Combinational from registered count only; it does not depend on same-cycle pop.
- id_valid = (count != 0).

Data path:
- Push writes {pc_addr_if, fetched_inst_if} at the write pointer on the rising edge.
- The entry is visible at the outputs in the next cycle: 1-cycle latency from push to id_valid when empty.
- Outputs show the head entry combinationally from storage while id_valid=1.
- While id_valid=0: pc_addr_id=0 and fetched_inst_id=NOP_INST (bubble). Decode never sees stale data.
- Head outputs are stable while id_valid=1 and id_ready=0 (stall holds).

Pointers and count:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- count +1 on push-only, -1 on pop-only, unchanged on push+pop or idle.

Boundary conditions:
- Empty with simultaneous push and id_ready=1: no pop (id_valid=0); entry appears next cycle.
- Full: if_ready=0, so push is impossible even if a pop happens the same cycle. if_ready rises the cycle after the pop.
- Push+pop at count=1: count stays 1; the new entry becomes head next cycle.

Flush:
- Highest priority among synchronous events.
- At the clock edge: count=0, both pointers=0.
- Same-cycle push and pop are both dropped.
- The next cycle shows the bubble.
- Flush with rst: rst dominates.

Never:
- Underflow or overflow of count.
- Reordering or duplication of entries.

Test Plan:
- Reset: rst=1 for 5 cycles, then release -> id_valid=0, fetched_inst_id=32'h00000013, pc_addr_id=0, count=0, if_ready=1.
- Streaming: id_ready=1; push pc 0x0,0x4,0x8 with insts 0x00100093,0x00200113,0x00300193 on consecutive cycles -> each appears on outputs one cycle after push, in order; count never exceeds 1.
- Stall to full: id_ready=0, push 5 words (pc 0x0..0x10) -> 4 accepted, if_ready=0 from cycle 4, count=4, head pc=0x0 held. Release id_ready -> drains 0x0,0x4,0x8,0xC in order. pc 0x10 is only accepted after if_ready returns to 1.
- Wrap-around: push/pop 10 entries with alternating stall cycles -> pointers wrap twice; output order matches input, no loss.
- Flush: count=3, assert flush with if_valid=1 (pc 0x40) -> next cycle count=0, id_valid=0, NOP shown. pc 0x40 is not stored. A following push of pc 0x80 appears as head.
- Async reset mid-stream: count=2, assert rst between clock edges -> id_valid=0 and count=0 immediately, before the next sys_clk edge.
